// File: rtl/rx_deframer_pkg.sv
// Shared HDLC constants, receive state encoding and the per-frame status bundle.
package hdlc_pkg;

  localparam logic [7:0]  HDLC_FLAG   = 8'h7E;
  localparam logic [15:0] CRC_INIT    = 16'hFFFF;
  localparam logic [15:0] CRC_POLY    = 16'h1021;
  localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

  typedef enum logic {
    HUNT,
    FRAME
  } rx_state_e;

  typedef struct packed {
    logic ok;
    logic err_crc;
    logic err_align;
    logic err_short;
    logic aborted;
  } rx_status_t;

endpackage

// File: rtl/rx_deframer_if.sv
// Receive-side payload and frame-status bundle; master drives, slave consumes.
interface rx_deframer_if;

  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_end;
  logic       frame_ok;
  logic       err_crc;
  logic       err_align;
  logic       err_short;
  logic       aborted;
  logic       in_frame;

  modport master (
    output data_out, data_valid, frame_end, frame_ok,
           err_crc, err_align, err_short, aborted, in_frame
  );

  modport slave (
    input data_out, data_valid, frame_end, frame_ok,
          err_crc, err_align, err_short, aborted, in_frame
  );

endinterface

// File: rtl/rx_deframer_crc16_step.sv
// One serial step of CRC-16/CCITT (poly 0x1021, MSB-out); shareable with the transmit framer.
module hdlc_crc16_step
  import hdlc_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic        din,
  output logic [15:0] crc_out
);

  logic fb;

  always_comb begin
    fb      = din ^ crc_in[15];
    crc_out = {crc_in[14:0], 1'b0} ^ (fb ? CRC_POLY : '0);
  end

endmodule

// File: rtl/rx_deframer.sv
// HDLC receive deframer: flag hunt, zero destuffing, LSB-first byte assembly,
// CRC-16 residue check, abort detection; payload delivered with the FCS held back.
module rx_deframer
  import hdlc_pkg::*;
#(
  parameter int unsigned MIN_PAYLOAD = 1
) (
  input  logic          netclk,
  input  logic          reset,
  input  logic          rxdata,
  rx_deframer_if.master rx
);

  localparam int unsigned MIN_BYTES = MIN_PAYLOAD + 2;

  rx_state_e  state, state_nxt;
  logic [7:0] win, win_nxt;
  logic [3:0] skip, skip_nxt;
  logic [2:0] raw_ones, raw_ones_nxt;
  logic [2:0] ones, ones_nxt;
  logic [15:0] crc, crc_nxt, crc_step;
  logic [7:0] sr, sr_nxt;
  logic [2:0] bitcnt, bitcnt_nxt;
  logic [7:0] bytecnt, bytecnt_nxt;
  logic       any_proc, any_proc_nxt;
  logic [7:0] hb0, hb0_nxt, hb1, hb1_nxt;
  logic [1:0] hb_cnt, hb_cnt_nxt;
  logic       fe_pend, fe_pend_nxt;
  rx_status_t st_pend, st_pend_nxt;
  rx_status_t status, status_nxt;
  logic [7:0] data_out, data_out_nxt;
  logic       data_valid, data_valid_nxt;
  logic       frame_end, frame_end_nxt;

  logic        pbit;
  logic        flag;
  logic        abort_det;
  logic        active;
  logic        stuff_del;
  logic        keep;
  logic        byte_done;
  logic [7:0]  byte_new;
  logic [15:0] crc_p;
  logic [2:0]  bitcnt_p;
  logic [7:0]  bytecnt_p;

  hdlc_crc16_step u_crc (
    .crc_in  (crc),
    .din     (pbit),
    .crc_out (crc_step)
  );

  always_comb begin
    win_nxt      = {rxdata, win[7:1]};
    pbit         = win[0];
    flag         = (win_nxt == HDLC_FLAG);
    raw_ones_nxt = rxdata ? ((raw_ones == 3'd7) ? 3'd7 : raw_ones + 3'd1) : '0;
    abort_det    = (raw_ones_nxt == 3'd7);

    // Abort detection looks at the incoming line; the bit leaving the window
    // on that cycle is dropped together with everything still in flight.
    active    = (state == FRAME) && (skip == '0) && !abort_det;
    stuff_del = active && !pbit && (ones == 3'd5);
    keep      = active && !stuff_del;

    ones_nxt = ones;
    if (active) begin
      if (stuff_del) ones_nxt = '0;
      else           ones_nxt = pbit ? ((ones == 3'd7) ? 3'd7 : ones + 3'd1) : '0;
    end

    crc_p     = keep ? crc_step : crc;
    byte_new  = {pbit, sr[7:1]};
    bitcnt_p  = keep ? bitcnt + 3'd1 : bitcnt;
    byte_done = keep && (bitcnt == 3'd7);
    bytecnt_p = (byte_done && (bytecnt != 8'hFF)) ? bytecnt + 8'd1 : bytecnt;

    state_nxt    = state;
    skip_nxt     = (skip != '0) ? skip - 4'd1 : skip;
    crc_nxt      = crc_p;
    sr_nxt       = keep ? byte_new : sr;
    bitcnt_nxt   = bitcnt_p;
    bytecnt_nxt  = bytecnt_p;
    any_proc_nxt = any_proc | active;

    hb0_nxt        = hb0;
    hb1_nxt        = hb1;
    hb_cnt_nxt     = hb_cnt;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;

    frame_end_nxt = fe_pend;
    status_nxt    = fe_pend ? st_pend : '0;
    fe_pend_nxt   = 1'b0;
    st_pend_nxt   = '0;

    // Two-deep holdback: a byte only leaves once two newer bytes exist, so
    // the trailing FCS pair is never presented.
    if (byte_done) begin
      if (hb_cnt == 2'd2) begin
        data_valid_nxt = 1'b1;
        data_out_nxt   = hb0;
        hb0_nxt        = hb1;
        hb1_nxt        = byte_new;
      end else if (hb_cnt == 2'd1) begin
        hb1_nxt    = byte_new;
        hb_cnt_nxt = 2'd2;
      end else begin
        hb0_nxt    = byte_new;
        hb_cnt_nxt = 2'd1;
      end
    end

    if (abort_det && (state == FRAME)) begin
      if (any_proc) begin
        fe_pend_nxt         = 1'b1;
        st_pend_nxt.aborted = 1'b1;
      end
      state_nxt  = HUNT;
      hb_cnt_nxt = '0;
    end else if (flag) begin
      if ((state == FRAME) && any_proc_nxt) begin
        fe_pend_nxt           = 1'b1;
        st_pend_nxt.err_crc   = (crc_p != CRC_RESIDUE);
        st_pend_nxt.err_align = (bitcnt_p != '0);
        st_pend_nxt.err_short = (32'(bytecnt_p) < MIN_BYTES);
        st_pend_nxt.ok        = !((crc_p != CRC_RESIDUE) || (bitcnt_p != '0) ||
                                  (32'(bytecnt_p) < MIN_BYTES));
      end
      state_nxt    = FRAME;
      skip_nxt     = 4'd8;
      crc_nxt      = CRC_INIT;
      bitcnt_nxt   = '0;
      bytecnt_nxt  = '0;
      ones_nxt     = '0;
      hb_cnt_nxt   = '0;
      any_proc_nxt = 1'b0;
    end
  end

  always_ff @(posedge netclk or posedge reset) begin
    if (reset) begin
      state      <= HUNT;
      win        <= '1;
      skip       <= '0;
      raw_ones   <= '0;
      ones       <= '0;
      crc        <= CRC_INIT;
      sr         <= '0;
      bitcnt     <= '0;
      bytecnt    <= '0;
      any_proc   <= 1'b0;
      hb0        <= '0;
      hb1        <= '0;
      hb_cnt     <= '0;
      fe_pend    <= 1'b0;
      st_pend    <= '0;
      status     <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_end  <= 1'b0;
    end else begin
      state      <= state_nxt;
      win        <= win_nxt;
      skip       <= skip_nxt;
      raw_ones   <= raw_ones_nxt;
      ones       <= ones_nxt;
      crc        <= crc_nxt;
      sr         <= sr_nxt;
      bitcnt     <= bitcnt_nxt;
      bytecnt    <= bytecnt_nxt;
      any_proc   <= any_proc_nxt;
      hb0        <= hb0_nxt;
      hb1        <= hb1_nxt;
      hb_cnt     <= hb_cnt_nxt;
      fe_pend    <= fe_pend_nxt;
      st_pend    <= st_pend_nxt;
      status     <= status_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      frame_end  <= frame_end_nxt;
    end
  end

  assign rx.data_out   = data_out;
  assign rx.data_valid = data_valid;
  assign rx.frame_end  = frame_end;
  assign rx.frame_ok   = status.ok;
  assign rx.err_crc    = status.err_crc;
  assign rx.err_align  = status.err_align;
  assign rx.err_short  = status.err_short;
  assign rx.aborted    = status.aborted;
  assign rx.in_frame   = (state == FRAME);

endmodule

// File: tb/tb_rx_deframer.sv
// Scoreboard bench for rx_deframer: frames are built from byte lists, expected
// bytes/status derived from framing rules and queued; a monitor checks outputs.
module tb_rx_deframer;

  localparam int unsigned MIN_PAYLOAD = 1;

  logic netclk = 1'b0;
  logic reset;
  logic rxdata;

  rx_deframer_if rx ();

  rx_deframer #(.MIN_PAYLOAD(MIN_PAYLOAD)) dut (
    .netclk (netclk),
    .reset  (reset),
    .rxdata (rxdata),
    .rx     (rx)
  );

  always #5 netclk = ~netclk;

  // st = {ok, err_crc, err_align, err_short, aborted}
  typedef struct packed {
    logic       is_status;
    logic [7:0] data;
    logic [4:0] st;
  } exp_t;

  exp_t       sb[$];
  int         errors = 0;
  int         checks = 0;
  logic [7:0] pay[$];
  logic       kept[$];
  logic       raw[$];

  function automatic logic [7:0] rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  // Byte-wise CRC-16/GENIBUS over the payload as it appears on the wire.
  function automatic logic [15:0] fcs_of_pay();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      c = c ^ {rev8(pay[i]), 8'h00};
      for (int j = 0; j < 8; j++) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return ~c;
  endfunction

  task automatic push_byte(input logic [7:0] d);
    exp_t e;
    e.is_status = 1'b0; e.data = d; e.st = '0;
    sb.push_back(e);
  endtask

  task automatic push_status(input logic [4:0] st);
    exp_t e;
    e.is_status = 1'b1; e.data = '0; e.st = st;
    sb.push_back(e);
  endtask

  task automatic kept_from_pay(input bit with_fcs);
    logic [15:0] f;
    kept.delete();
    foreach (pay[i]) for (int j = 0; j < 8; j++) kept.push_back(pay[i][j]);
    if (with_fcs) begin
      f = fcs_of_pay();
      for (int j = 15; j >= 0; j--) kept.push_back(f[j]);
    end
  endtask

  task automatic stuff();
    int run;
    run = 0;
    raw.delete();
    foreach (kept[i]) begin
      raw.push_back(kept[i]);
      if (kept[i]) begin
        run++;
        if (run == 5) begin raw.push_back(1'b0); run = 0; end
      end else run = 0;
    end
  endtask

  // Expected outcome of a frame closed by a flag: every complete byte but the
  // last two is delivered; status from residue, alignment and byte count.
  task automatic model_frame();
    int nb;
    logic [15:0] c;
    logic [7:0] b;
    logic e_crc, e_al, e_sh;
    nb = kept.size() / 8;
    for (int i = 0; i + 2 < nb; i++) begin
      for (int j = 0; j < 8; j++) b[j] = kept[8*i+j];
      push_byte(b);
    end
    if (kept.size() > 0) begin
      c = 16'hFFFF;
      foreach (kept[i]) c = {c[14:0], 1'b0} ^ ((kept[i] ^ c[15]) ? 16'h1021 : 16'h0000);
      e_crc = (c != 16'h1D0F);
      e_al  = (kept.size() % 8) != 0;
      e_sh  = nb < int'(MIN_PAYLOAD + 2);
      push_status({!(e_crc || e_al || e_sh), e_crc, e_al, e_sh, 1'b0});
    end
  endtask

  // Abort fires on the 7th raw one; bits that had left the 8-bit window before
  // that point (past the 8 flag bits) are the only ones decoded.
  task automatic model_abort();
    int run, k, np, nb;
    logic kp[$];
    logic [7:0] b;
    run = 0; k = 0;
    for (int i = 0; i < raw.size(); i++) begin
      run = raw[i] ? run + 1 : 0;
      if (run == 7) begin k = i + 1; break; end
    end
    np = k - 9;
    run = 0;
    for (int i = 0; i < np; i++) begin
      if (!raw[i] && run == 5) run = 0;
      else begin kp.push_back(raw[i]); run = raw[i] ? run + 1 : 0; end
    end
    nb = kp.size() / 8;
    for (int i = 0; i + 2 < nb; i++) begin
      for (int j = 0; j < 8; j++) b[j] = kp[8*i+j];
      push_byte(b);
    end
    if (np >= 1) push_status(5'b00001);
  endtask

  task automatic send_bit(input logic b);
    @(negedge netclk);
    rxdata = b;
  endtask

  task automatic send_flag();
    logic [7:0] f;
    f = 8'h7E;
    for (int i = 0; i < 8; i++) send_bit(f[i]);
  endtask

  task automatic send_ones(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b1);
  endtask

  task automatic send_raw();
    foreach (raw[i]) send_bit(raw[i]);
  endtask

  task automatic run_frame();
    model_frame();
    stuff();
    send_flag();
    send_raw();
    send_flag();
  endtask

  task automatic run_abort();
    kept_from_pay(1'b0);
    stuff();
    for (int i = 0; i < 8; i++) raw.push_back(1'b1);
    model_abort();
    send_flag();
    send_raw();
    send_ones(2);
  endtask

  task automatic gap();
    if ($urandom_range(0, 1) == 0) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) send_flag();
    end else send_ones(8 + int'($urandom_range(0, 4)));
  endtask

  task automatic check_zero(input string name);
    logic [15:0] v;
    v = {rx.data_out, rx.data_valid, rx.frame_end, rx.frame_ok, rx.err_crc,
         rx.err_align, rx.err_short, rx.aborted, rx.in_frame};
    checks++;
    if (v !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%04h expected 0000", name, v);
    end
  endtask

  always @(negedge netclk) begin
    exp_t e;
    if (reset !== 1'b1) begin
      if (rx.data_valid && rx.frame_end) begin
        checks++; errors++;
        $display("FAIL overlap: data_valid and frame_end both 1, expected not together");
      end
      if (rx.data_valid === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL byte: got %02h expected no output", rx.data_out);
        end else begin
          e = sb.pop_front();
          if (e.is_status || rx.data_out !== e.data) begin
            errors++;
            $display("FAIL byte: got %02h expected %s %02h", rx.data_out,
                     e.is_status ? "status" : "byte", e.data);
          end
        end
      end
      if (rx.frame_end === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL status: got frame_end expected no output");
        end else begin
          e = sb.pop_front();
          if (!e.is_status || {rx.frame_ok, rx.err_crc, rx.err_align, rx.err_short, rx.aborted} !== e.st) begin
            errors++;
            $display("FAIL status: got ok/crc/align/short/abort=%05b expected %s %05b",
                     {rx.frame_ok, rx.err_crc, rx.err_align, rx.err_short, rx.aborted},
                     e.is_status ? "status" : "byte", e.st);
          end
        end
      end
    end
  end

  initial begin
    int kind, n, idx, extra;
    rxdata = 1'b1;
    reset  = 1'b1;
    repeat (3) @(negedge netclk);
    #1 check_zero("reset");
    reset = 1'b0;
    send_ones(10);

    pay = '{8'h01, 8'h02};               kept_from_pay(1'b1); run_frame(); gap();
    pay = '{8'hFF, 8'h3E, 8'h7E};        kept_from_pay(1'b1); run_frame(); gap();
    pay = '{8'h01, 8'h02};               kept_from_pay(1'b1);
    kept[20] = ~kept[20];                run_frame(); gap();
    pay = '{8'h12};                      run_abort();
    pay = '{8'h55};                      kept_from_pay(1'b1); run_frame(); gap();
    pay = '{8'h01};                      kept_from_pay(1'b1);
    for (int i = 0; i < 3; i++) kept.push_back(1'b0);
    run_frame(); gap();
    pay = '{8'h01};                      kept_from_pay(1'b0); run_frame(); gap();
    send_ones(12);
    for (int i = 0; i < 5; i++) send_flag();

    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      n    = int'($urandom_range(0, 5));
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
      if (kind == 3) run_abort();
      else begin
        kept_from_pay(1'b1);
        if (kind == 1) begin
          idx = int'($urandom_range(0, kept.size() - 1));
          kept[idx] = ~kept[idx];
        end else if (kind == 2) begin
          extra = int'($urandom_range(1, 7));
          for (int i = 0; i < extra; i++) kept.push_back(1'($urandom_range(0, 1)));
        end
        run_frame();
      end
      gap();
    end

    // Reset asserted in the middle of an open frame.
    send_flag();
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    #2;
    checks++;
    if (rx.in_frame !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL pre_reset: in_frame=%0b pending=%0d expected 1 and 0", rx.in_frame, sb.size());
    end
    reset = 1'b1;
    #1 check_zero("reset_mid");
    @(negedge netclk);
    reset  = 1'b0;
    rxdata = 1'b1;
    send_ones(10);
    pay = '{8'hA5, 8'h5A};               kept_from_pay(1'b1); run_frame();

    send_ones(40);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected outputs never seen, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
